// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared definitions for the interrupt scheduler slice.
//   - bridge base address of the scheduler register block
//   - word offsets (addr[3:2]) of MASK / PEND / CLAIM / EOI
//   - FSM state encoding
//   - one-hot decode helper for the 6-bit HWInt vector
package irq_sched_pkg;

  localparam logic [15:0] IRQ_SCHED_BASE = 16'h7f40;

  localparam logic [1:0] OFF_MASK  = 2'd0;
  localparam logic [1:0] OFF_PEND  = 2'd1;
  localparam logic [1:0] OFF_CLAIM = 2'd2;
  localparam logic [1:0] OFF_EOI   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  function automatic logic [5:0] onehot6(input logic [2:0] id);
    return 6'b000001 << id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: 6-bit fixed-priority encoder, lowest index wins.
//   req   in  6  candidate request bits
//   valid out 1  any request present
//   id    out 3  index of the winning request (0 when none)
module irq_prio_enc (
  input  logic [5:0] req,
  output logic       valid,
  output logic [2:0] id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sched.sv
// irq_sched: memory-mapped interrupt scheduler (bridge base 0x7f40).
// Latches pending events from up to 6 sources (edge or level per source),
// masks them, picks the lowest pending index and sequences it through a
// claim / end-of-interrupt handshake so only one source is in service.
//   clk, reset      system clock, synchronous active-high reset
//   src[5:0]        raw interrupt sources, synchronous to clk
//   sel, we         bridge decode hit and write strobe
//   addr[1:0]       word offset: 0 MASK, 1 PEND, 2 CLAIM, 3 EOI
//   wdata[31:0]     write data
//   rdata[31:0]     read data, combinational from addr
//   hwint[5:0]      one-hot request to CP0 Cause.IP[7:2]
//   irq             OR of hwint
//   irq_id[2:0]     index of the presented source
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int unsigned N_SRC     = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  src,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  hwint,
  output logic        irq,
  output logic [2:0]  irq_id
);

  // Sources at or above N_SRC are tied off everywhere.
  localparam logic [5:0] SRC_EN = 6'((7'd1 << N_SRC) - 7'd1);

  state_e     state_q, state_d;
  logic [5:0] src_q, src_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] mask_q, mask_d;
  logic [2:0] isr_id_q, isr_id_d;

  logic       win_valid;
  logic [2:0] win_id;
  logic [5:0] pend_set;
  logic [5:0] pend_clr;
  logic       wr_mask, wr_claim, wr_eoi;
  logic       present;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:6];

  assign wr_mask  = sel && we && (addr == OFF_MASK);
  assign wr_claim = sel && we && (addr == OFF_CLAIM);
  assign wr_eoi   = sel && we && (addr == OFF_EOI);

  irq_prio_enc u_prio (
    .req   (pend_q & mask_q),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    src_d    = src & SRC_EN;
    pend_set = ((EDGE_MASK & src & ~src_q) | (~EDGE_MASK & src)) & SRC_EN;
    mask_d   = wr_mask ? (wdata[5:0] & SRC_EN) : mask_q;
  end

  // FSM next state; the claim clear is applied before the set so a new
  // event arriving on the claim edge is never lost.
  always_comb begin
    state_d  = state_q;
    pend_clr = '0;
    isr_id_d = isr_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!win_valid) begin
          state_d = ST_IDLE;
        end else if (wr_claim) begin
          state_d  = ST_SERVICE;
          pend_clr = onehot6(win_id);
          isr_id_d = win_id;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      isr_id_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      isr_id_q <= isr_id_d;
    end
  end

  // Gate with win_valid: a mask write can empty the candidate set for the
  // one cycle before the FSM falls back to IDLE.
  assign present = (state_q == ST_REQ) && win_valid;
  assign hwint   = present ? onehot6(win_id) : '0;
  assign irq     = |hwint;
  assign irq_id  = present ? win_id : '0;

  always_comb begin
    rdata = '0;
    case (addr)
      OFF_MASK:  rdata = {26'b0, mask_q};
      OFF_PEND:  rdata = {26'b0, pend_q};
      OFF_CLAIM: rdata = {win_valid, 28'b0, win_id};
      OFF_EOI:   rdata = {(state_q == ST_SERVICE), 28'b0, isr_id_q};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Memory-mapped interrupt scheduler for the MIPS microsystem. It sits on the system bridge at base 0x7f40, beside timer0 (0x7f00), timer1 (0x7f10) and the external interrupt port (0x7f20).
- Collects up to 6 hardware sources (timers, external interrupt), latches pending events and applies a mask.
- Picks one source by fixed priority and presents it to CP0 as a one-hot HWInt vector.
- Each interrupt is sequenced through a claim / end-of-interrupt handshake driven by handler stores, so only one source is in service at a time.

Parameters:
- N_SRC, 6, number of sources (1..6); bits above N_SRC-1 read 0 and never assert.
- EDGE_MASK, 6'b000111, per-source mode: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src  in  6  raw interrupt sources, synchronous to clk
- sel  in  1  bridge decode hit for 0x7f40..0x7f4f
- addr  in  2  word offset (addr[3:2])
- we  in  1  write strobe (qualified by sel)
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- hwint  out  6  one-hot request to CP0 Cause.IP[7:2]
- irq  out  1  OR of hwint
- irq_id  out  3  index of the selected source

Behaviour:
- Register map:
  - 0x0 MASK: RW, bits [5:0].
  - 0x4 PEND: RO, pending bits [5:0].
  - 0x8 CLAIM: write = claim; read = {valid[31], 28'b0, id[2:0]}.
  - 0xC EOI: write = end-of-interrupt; read = {busy[31], 28'b0, in_service_id[2:0]}.
- Writes take effect at the posedge where sel & we.
- Writes to PEND are ignored. Only bits [5:0] of wdata are stored to MASK.
- Edge detect: src_q is a register of src. An edge source sets pend[i] at any posedge where src[i] & ~src_q[i].
- Level source: sets pend[i] at every posedge where src[i] = 1.
- Simultaneous set and clear of the same pend bit: set wins, so no event is lost.
- Selection (combinational): cand = pend & mask. The winner is the lowest index set. valid = |cand.
- FSM states:
  - IDLE:
    - valid -> REQ.
    - CLAIM and EOI writes are ignored.
  - REQ:
    - hwint = onehot(winner), irq = 1, irq_id = winner.
    - The winner may change while in REQ if a higher-priority source becomes pending.
    - !valid (masked or cleared) -> IDLE.
    - CLAIM write -> SERVICE: clear pend[winner], latch in_service_id = winner.
  - SERVICE:
    - hwint = 0, irq = 0, busy = 1.
    - New events keep accumulating in pend.
    - CLAIM writes are ignored.
    - EOI write -> IDLE.
    - Re-arbitration happens from IDLE, so a remaining pending source re-asserts 2 cycles after the EOI posedge.
- Latency: a source first sampled high at posedge k sets pend at k. The FSM enters REQ at k+1, so irq is high during cycle k+1..k+2.
- Outputs hwint, irq and irq_id are decoded from registered state, with no combinational path from src.
- Reset (synchronous, any state including mid-SERVICE):
  - State -> IDLE; pend, mask, src_q, in_service_id all 0.
  - Outputs hwint = 0, irq = 0, irq_id = 0, rdata follows the cleared registers.
- A level source held high during SERVICE re-pends immediately after claim. This is legal and is serviced after EOI.

Decomposition:
- Shared package holds:
  - Address offsets (MASK, PEND, CLAIM, EOI).
  - State encoding (IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2).
  - Base address 0x7f40 for the bridge decoder.
- One sub-module, irq_prio_enc: a 6-bit fixed-priority encoder producing {valid, id[2:0]}.
- The FSM, registers and edge detection stay in irq_sched.

Test Plan:
- Reset, then MASK = 0x3f, pulse src[2] (edge source) for 1 cycle -> irq = 1, hwint = 6'b000100, irq_id = 2 from the next cycle; PEND reads 0x4.
- In REQ for id 2, pulse src[0] -> irq_id switches to 0, hwint = 6'b000001. Write CLAIM -> irq = 0, PEND = 0x4, EOI read = 0x80000000. Write EOI -> irq re-asserts with irq_id = 2 two cycles later.
- MASK = 0x00, pulse src[1] -> irq stays 0, PEND = 0x2. Write MASK = 0x02 -> irq = 1, irq_id = 1 the cycle after the write.
- Hold src[4] high (level source), claim, keep src[4] high -> PEND bit 4 is set again the next cycle. After EOI, irq re-asserts with id 4. Drop src[4] and clear it by claim + EOI -> irq stays 0.
- src[1] edge on the same posedge as the CLAIM clearing pend[1] -> pend[1] remains 1 after the claim.
- Assert reset while in SERVICE with PEND = 0x3 -> next cycle state IDLE, PEND = 0, MASK = 0, irq = 0. A CLAIM write afterwards has no effect.
